// File: rtl/axil2sreg.sv
// axil2sreg: AXI4-Lite slave bridged onto the strobed register bus, one access in flight.
// Define SREG_RD_PIPE_EN for a two-cycle read strobe (slaves with registered dout).
module axil2sreg #(
   parameter logic [31:0] WIN_BASE = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic [31:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [31:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic        sreg_en,
   output logic        sreg_wen,
   output logic [17:0] sreg_addr,
   output logic [31:0] sreg_wdata,
   input  logic [31:0] sreg_rdata
);
   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP} state_t;
   state_t      state_q;
   logic        prio_q, en_q, wen_q, bvalid_q, rvalid_q;
   logic [1:0]  err_q, bresp_q, rresp_q, werr, rerr;
   logic [17:0] addr_q;
   logic [31:0] wdata_q, rdata_q;
   logic        wr_cand, rd_cand, grant_wr, grant_rd, rd_done, unused_addr_lsbs;
   assign wr_cand = s_awvalid & s_wvalid;
   assign rd_cand = s_arvalid;
   assign grant_wr = (state_q == IDLE) & wr_cand & (~rd_cand | ~prio_q);
   assign grant_rd = (state_q == IDLE) & rd_cand & (~wr_cand | prio_q);
   // Decode error outranks the partial-strobe error.
   assign werr = (s_awaddr[31:18] != WIN_BASE[31:18]) ? 2'b11 : (s_wstrb != 4'hF) ? 2'b10 : 2'b00;
   assign rerr = (s_araddr[31:18] != WIN_BASE[31:18]) ? 2'b11 : 2'b00;
   assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};
`ifdef SREG_RD_PIPE_EN
   logic ph_q;
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) ph_q <= 1'b0;
      else       ph_q <= (state_q == READ) & ~ph_q;
   end
   assign rd_done = ph_q;
`else
   assign rd_done = 1'b1;
`endif
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         en_q     <= 1'b0;
         wen_q    <= 1'b0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= 2'b00;
         bresp_q  <= 2'b00;
         rresp_q  <= 2'b00;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_wr) begin
                  state_q <= WRITE;
                  addr_q  <= {s_awaddr[17:2], 2'b00};
                  wdata_q <= s_wdata;
                  err_q   <= werr;
                  en_q    <= werr == 2'b00;
                  wen_q   <= werr == 2'b00;
                  prio_q  <= 1'b1;
               end else if (grant_rd) begin
                  state_q <= READ;
                  addr_q  <= {s_araddr[17:2], 2'b00};
                  err_q   <= rerr;
                  en_q    <= rerr == 2'b00;
                  prio_q  <= 1'b0;
               end
            end
            WRITE: begin
               en_q     <= 1'b0;
               wen_q    <= 1'b0;
               bvalid_q <= 1'b1;
               bresp_q  <= err_q;
               state_q  <= WRESP;
            end
            WRESP: if (s_bready) begin
               bvalid_q <= 1'b0;
               state_q  <= IDLE;
            end
            READ: if (rd_done) begin
               en_q     <= 1'b0;
               rvalid_q <= 1'b1;
               rresp_q  <= err_q;
               rdata_q  <= (err_q == 2'b00) ? sreg_rdata : '0;
               state_q  <= RRESP;
            end
            RRESP: if (s_rready) begin
               rvalid_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign s_awready  = grant_wr;
   assign s_wready   = grant_wr;
   assign s_arready  = grant_rd;
   assign s_bvalid   = bvalid_q;
   assign s_bresp    = bresp_q;
   assign s_rvalid   = rvalid_q;
   assign s_rresp    = rresp_q;
   assign s_rdata    = rdata_q;
   assign sreg_en    = en_q;
   assign sreg_wen   = wen_q;
   assign sreg_addr  = addr_q;
   assign sreg_wdata = wdata_q;
endmodule
